fma16: RTL and testbench

FMA16 -- requirements
Module: fma16

---
 rtl/fma16.sv | 154 +++++++++++++++
 tb/tb_fma16.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fma16.sv
// fma16: combinational binary16 fused multiply-add, single final rounding.
// Exact sum in a wide fixed-point window; only the sticky flags are registered.
module fma16 (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic [15:0] z,
  input  logic        mul,
  input  logic        add,
  input  logic        negp,
  input  logic        negz,
  input  logic [1:0]  roundmode,
  output logic [15:0] result,
  output logic [3:0]  flags,
  output logic [3:0]  flags_acc
);

  localparam int W = 84;

  function automatic logic [10:0] sig(input logic [14:0] h);
    return {|h[14:10], h[9:0]};
  endfunction

  function automatic logic [6:0] expo(input logic [14:0] h);
    return (h[14:10] == 5'd0) ? 7'd1 : {2'b0, h[14:10]};
  endfunction

  function automatic logic isnan(input logic [14:0] h);
    return (&h[14:10]) & (|h[9:0]);
  endfunction

  function automatic logic isinf(input logic [14:0] h);
    return (&h[14:10]) & ~(|h[9:0]);
  endfunction

  logic [15:0] yv;
  assign yv = mul ? y : 16'h3C00;

  logic sp, sz, nan_in, snan_any, inf0, pinf, zi, invalid, special;
  logic xzero, yzero;

  assign sp    = x[15] ^ yv[15] ^ negp;
  assign sz    = z[15] ^ negz;
  assign xzero = ~|x[14:0];
  assign yzero = ~|yv[14:0];

  assign nan_in = isnan(x[14:0]) | isnan(yv[14:0])
                | (add & isnan(z[14:0]));
  assign snan_any = (isnan(x[14:0]) & ~x[9])
                  | (isnan(yv[14:0]) & ~yv[9])
                  | (add & isnan(z[14:0]) & ~z[9]);
  assign inf0 = (isinf(x[14:0]) & yzero)
              | (xzero & isinf(yv[14:0]));
  assign pinf = (isinf(x[14:0]) | isinf(yv[14:0]))
              & ~isnan(x[14:0]) & ~isnan(yv[14:0]) & ~inf0;
  assign zi      = add & isinf(z[14:0]);
  assign invalid = snan_any | inf0 | (pinf & zi & (sp != sz));
  assign special = nan_in | inf0 | pinf | zi;

  // LSB of the window weighs 2^-48, the smallest exact product bit.
  logic [21:0] pm;
  logic [10:0] zm;
  logic [6:0]  psh, zsh;
  logic [W-1:0] pmag, zmag, m;
  logic signed [W:0] pext, zext, sum;
  logic neg;

  assign pm   = sig(x[14:0]) * sig(yv[14:0]);
  assign psh  = expo(x[14:0]) + expo(yv[14:0]) - 7'd2;
  assign zm   = add ? sig(z[14:0]) : 11'd0;
  assign zsh  = expo(z[14:0]) + 7'd23;
  assign pmag = W'(pm) << psh;
  assign zmag = W'(zm) << zsh;
  assign pext = {1'b0, pmag};
  assign zext = {1'b0, zmag};
  assign sum  = (sp ? -pext : pext) + (sz ? -zext : zext);
  assign neg  = sum[W];
  assign m    = neg ? W'(-sum) : W'(sum);

  logic [6:0] k;
  always_comb begin
    k = 7'd0;
    for (int i = 0; i < W; i++)
      if (m[i]) k = 7'(i);
  end

  logic        normal, g, st, inex, inc;
  logic [6:0]  lsb, base;
  logic [10:0] q;
  logic [11:0] qr;
  logic [16:0] res;
  logic [W-1:0] mask;

  assign normal = k >= 7'd34;
  assign lsb    = normal ? k - 7'd10 : 7'd24;
  assign base   = normal ? k - 7'd34 : 7'd0;
  assign q      = 11'(m >> lsb);
  assign g      = m[lsb - 7'd1];
  assign mask   = {W{1'b1}} << (lsb - 7'd1);
  assign st     = |(m & ~mask);
  assign inex   = g | st;

  always_comb begin
    case (roundmode)
      2'b00:   inc = 1'b0;
      2'b01:   inc = g & (st | q[0]);
      2'b10:   inc = neg & inex;
      default: inc = ~neg & inex;
    endcase
  end

  // Mantissa carry-out rolls into the exponent field by plain addition.
  assign qr  = {1'b0, q} + {11'd0, inc};
  assign res = {base, 10'd0} + {5'd0, qr};

  logic        ovf, zsign;
  logic [14:0] ovmag;

  assign ovf   = res >= 17'h7C00;
  assign zsign = ~add ? sp : (sp == sz) ? sp : (roundmode == 2'b10);

  always_comb begin
    case (roundmode)
      2'b00:   ovmag = 15'h7BFF;
      2'b01:   ovmag = 15'h7C00;
      2'b10:   ovmag = neg ? 15'h7C00 : 15'h7BFF;
      default: ovmag = neg ? 15'h7BFF : 15'h7C00;
    endcase
  end

  always_comb begin
    result = {neg, res[14:0]};
    flags  = {2'b00, (res < 17'h0400) & inex, inex};
    if (special) begin
      flags = {invalid, 3'b000};
      if (invalid | nan_in) result = 16'h7E00;
      else if (pinf)        result = {sp, 15'h7C00};
      else                  result = {sz, 15'h7C00};
    end else if (m == '0) begin
      result = {zsign, 15'd0};
      flags  = 4'b0000;
    end else if (ovf) begin
      result = {neg, ovmag};
      flags  = 4'b0101;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) flags_acc <= 4'b0000;
    else       flags_acc <= flags_acc | flags;
  end

endmodule

// File: tb/tb_fma16.sv
// tb_fma16: directed and random vectors for fma16 against an
// exact-arithmetic reference; also tracks the sticky flag register.
module tb_fma16;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] x, y, z;
  logic        mul, add, negp, negz;
  logic [1:0]  roundmode;
  logic [15:0] result;
  logic [3:0]  flags;
  logic [3:0]  flags_acc;

  fma16 dut (
    .clk(clk), .reset(reset),
    .x(x), .y(y), .z(z),
    .mul(mul), .add(add),
    .negp(negp), .negz(negz),
    .roundmode(roundmode),
    .result(result), .flags(flags),
    .flags_acc(flags_acc)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  logic [3:0] accm = 4'b0;
  logic [3:0] curf = 4'b0;

  task automatic check(input string tag,
                       input logic [15:0] got,
                       input logic [15:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic bit isnan(input logic [14:0] h);
    return h[14:10] == 5'd31 && h[9:0] != 10'd0;
  endfunction
  function automatic bit issnan(input logic [14:0] h);
    return isnan(h) && !h[9];
  endfunction
  function automatic bit isinf(input logic [14:0] h);
    return h[14:10] == 5'd31 && h[9:0] == 10'd0;
  endfunction
  function automatic bit iszero(input logic [14:0] h);
    return h == 15'd0;
  endfunction

  // magnitude in units of 2^-48
  function automatic logic [127:0] units(input logic [14:0] h);
    if (h[14:10] == 5'd0) return 128'(h[9:0]) << 24;
    return (128'd1024 + 128'(h[9:0])) << (int'(h[14:10]) + 23);
  endfunction

  task automatic ref_fma(input logic [15:0] a, b, c,
                         input logic [7:0] ctrl,
                         output logic [15:0] r,
                         output logic [3:0] f);
    logic [1:0] rm;
    logic mu, ad, np, nz, sp, sz, s, nanv, sig, inf0, pinf, zinf, inexact, up;
    logic [15:0] bv;
    logic [191:0] pp;
    logic [127:0] pu, zu, A, q, rem, half, R;
    int e, u, e2;
    {rm, mu, ad, np, nz} = ctrl[5:0];
    bv = mu ? b : 16'h3C00;
    sp = a[15] ^ bv[15] ^ np;
    sz = c[15] ^ nz;
    nanv = isnan(a[14:0]) || isnan(bv[14:0]) || (ad && isnan(c[14:0]));
    sig  = issnan(a[14:0]) || issnan(bv[14:0]) || (ad && issnan(c[14:0]));
    inf0 = (isinf(a[14:0]) && iszero(bv[14:0]))
        || (iszero(a[14:0]) && isinf(bv[14:0]));
    pinf = (isinf(a[14:0]) || isinf(bv[14:0])) && !nanv && !inf0;
    zinf = ad && isinf(c[14:0]);
    f = 4'b0000;
    if (sig || inf0 || (pinf && zinf && sp != sz)) begin
      r = 16'h7E00; f = 4'b1000;
    end else if (nanv) r = 16'h7E00;
    else if (pinf) r = {sp, 15'h7C00};
    else if (zinf) r = {sz, 15'h7C00};
    else begin
      pp = 192'(units(a[14:0])) * 192'(units(bv[14:0]));
      pu = 128'(pp >> 48);
      zu = ad ? units(c[14:0]) : 128'd0;
      if (sp == sz)      begin A = pu + zu; s = sp; end
      else if (pu >= zu) begin A = pu - zu; s = sp; end
      else               begin A = zu - pu; s = sz; end
      if (A == 0) begin
        if (!ad)           r = {sp, 15'd0};
        else if (sp == sz) r = {sp, 15'd0};
        else               r = {rm == 2'b10, 15'd0};
      end else begin
        e = 0;
        for (int i = 0; i < 128; i++) if (A[i]) e = i;
        u = (e - 10 > 24) ? e - 10 : 24;
        q = A >> u;
        rem = A - (q << u);
        half = 128'd1 << (u - 1);
        inexact = rem != 0;
        case (rm)
          2'b00: up = 0;
          2'b01: up = rem > half || (rem == half && q[0]);
          2'b10: up = s && inexact;
          default: up = !s && inexact;
        endcase
        R = (q + 128'(up)) << u;
        if (R >= (128'd1 << 64)) begin
          f = 4'b0101;
          case (rm)
            2'b00: r = {s, 15'h7BFF};
            2'b01: r = {s, 15'h7C00};
            2'b10: r = {s, s ? 15'h7C00 : 15'h7BFF};
            default: r = {s, s ? 15'h7BFF : 15'h7C00};
          endcase
        end else begin
          if (R < (128'd1 << 34)) r = {s, 15'(R >> 24)};
          else begin
            e2 = 0;
            for (int i = 0; i < 128; i++) if (R[i]) e2 = i;
            r = {s, 5'(e2 - 33), 10'((R >> (e2 - 10)) - 128'd1024)};
          end
          f = {2'b00, (R < (128'd1 << 34)) && inexact, inexact};
        end
      end
    end
  endtask

  task automatic step(input logic [15:0] a, b, c,
                      input logic [7:0] ctrl,
                      input logic [15:0] er,
                      input logic [3:0] ef,
                      input string tag);
    @(posedge clk);
    accm = reset ? 4'b0 : (accm | curf);
    #1;
    check({tag, "/acc"}, {12'd0, flags_acc}, {12'd0, accm});
    x = a; y = b; z = c;
    {roundmode, mul, add, negp, negz} = ctrl[5:0];
    #5;
    check({tag, "/res"}, result, er);
    check({tag, "/flg"}, {12'd0, flags}, {12'd0, ef});
    curf = ef;
  endtask

  function automatic logic [15:0] rand_half();
    logic [15:0] h;
    h = 16'($urandom);
    case ($urandom_range(0, 15))
      0: h[14:0] = 15'd0;
      1: h[14:10] = 5'd0;
      2: h[14:0] = 15'h7C00;
      3: h[14:9] = 6'h3F;
      4: h[14:0] = {6'h3E, 9'($urandom) | 9'd1};
      5: h[14:10] = 5'(30 - $urandom_range(0, 2));
      6, 7, 8: h[14:10] = 5'($urandom_range(10, 20));
      default: if (h[14:10] == 5'd31) h[14:10] = 5'd17;
    endcase
    return h;
  endfunction

  localparam int ND = 20;
  logic [75:0] dirv [ND] = '{
    {16'h4000, 16'h4200, 16'h0000, 8'h18, 16'h4600, 4'b0000},
    {16'h3C00, 16'h3C00, 16'h3C00, 8'h1C, 16'h4000, 4'b0000},
    {16'h3C00, 16'h3C00, 16'h3C00, 8'h1D, 16'h0000, 4'b0000},
    {16'h3C01, 16'h3C01, 16'h0000, 8'h08, 16'h3C02, 4'b0001},
    {16'h3C01, 16'h3C01, 16'h0000, 8'h38, 16'h3C03, 4'b0001},
    {16'h7BFF, 16'h4000, 16'h0000, 8'h18, 16'h7C00, 4'b0101},
    {16'h7BFF, 16'h4000, 16'h0000, 8'h08, 16'h7BFF, 4'b0101},
    {16'h0400, 16'h0400, 16'h0000, 8'h18, 16'h0000, 4'b0011},
    {16'h7C00, 16'h0000, 16'h0000, 8'h18, 16'h7E00, 4'b1000},
    {16'h3C00, 16'h3C00, 16'h3C00, 8'h2D, 16'h8000, 4'b0000},
    {16'h7BFF, 16'h4000, 16'h0000, 8'h28, 16'h7BFF, 4'b0101},
    {16'h7BFF, 16'h4000, 16'h0000, 8'h2A, 16'hFC00, 4'b0101},
    {16'h7E01, 16'h3C00, 16'h0000, 8'h18, 16'h7E00, 4'b0000},
    {16'h7D00, 16'h3C00, 16'h0000, 8'h18, 16'h7E00, 4'b1000},
    {16'h7C00, 16'h3C00, 16'h7C00, 8'h1D, 16'h7E00, 4'b1000},
    {16'h7C00, 16'h4000, 16'h3C00, 8'h1C, 16'h7C00, 4'b0000},
    {16'h3C00, 16'h1234, 16'h0000, 8'h10, 16'h3C00, 4'b0000},
    {16'h0000, 16'h3C00, 16'h0000, 8'h1A, 16'h8000, 4'b0000},
    {16'h0001, 16'h3C00, 16'h0001, 8'h1C, 16'h0002, 4'b0000},
    {16'h8000, 16'h3C00, 16'h8000, 8'h1C, 16'h8000, 4'b0000}
  };

  initial begin
    logic [15:0] a, b, c, er;
    logic [7:0]  ct;
    logic [3:0]  ef;
    int ez;
    reset = 1'b1;
    x = 16'd0; y = 16'd0; z = 16'd0;
    {roundmode, mul, add, negp, negz} = 6'd0;

    step(16'h4000, 16'h4200, 16'h0000, 8'h18, 16'h4600, 4'b0000, "in_reset");
    reset = 1'b0;
    for (int i = 0; i < ND; i++)
      step(dirv[i][75:60], dirv[i][59:44], dirv[i][43:28], dirv[i][27:20],
           dirv[i][19:4], dirv[i][3:0], $sformatf("dir%0d", i));

    reset = 1'b1;
    step(16'h4000, 16'h4200, 16'h0000, 8'h18, 16'h4600, 4'b0000, "clr");
    reset = 1'b0;
    step(16'h7C00, 16'h0000, 16'h0000, 8'h18, 16'h7E00, 4'b1000, "inv");
    step(16'h4000, 16'h4200, 16'h0000, 8'h18, 16'h4600, 4'b0000, "post_inv");
    check("sticky_inv", {12'd0, flags_acc}, 16'h0008);
    reset = 1'b1;
    step(16'h3C01, 16'h3C01, 16'h0000, 8'h08, 16'h3C02, 4'b0001, "rst_edge");
    check("sticky_clr", {12'd0, flags_acc}, 16'h0000);
    reset = 1'b0;
    step(16'h4000, 16'h4200, 16'h0000, 8'h18, 16'h4600, 4'b0000, "resume");
    check("sticky_resume", {12'd0, flags_acc}, 16'h0001);

    for (int i = 0; i < 3000; i++) begin
      a = rand_half();
      b = rand_half();
      c = rand_half();
      if ($urandom_range(0, 3) == 0) begin
        ez = int'(a[14:10]) + int'(b[14:10]) - 15;
        if (ez >= 1 && ez <= 30) c[14:10] = 5'(ez);
      end
      ct = {2'b00, 2'($urandom), $urandom_range(0, 3) != 0,
            $urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom)};
      reset = ($urandom_range(0, 63) == 0);
      ref_fma(a, b, c, ct, er, ef);
      step(a, b, c, ct, er, ef, $sformatf("rnd%0d", i));
    end

    @(posedge clk);
    accm = reset ? 4'b0 : (accm | curf);
    #1;
    check("final_acc", {12'd0, flags_acc}, {12'd0, accm});
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
